// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the strided pool output buffer.
// Geometry functions are evaluated at elaboration time only.
package pool_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_NEXT,
        START,
        DRAIN
    } state_t;

    function automatic int out_dim(input int img, input int k, input int s);
        return (img - k) / s + 1;
    endfunction

    // Never narrower than one bit, so single-entry or stride-1 cases still elaborate
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obuf_ram.sv
// Simple dual-port buffer: one write port, one read port with a registered output.
// The read register clears on reset so the downstream data bus starts at zero.
module obuf_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pool_stride_obuf.sv
// Keeps in-bounds, stride-aligned max-pool results for one image and streams them
// to the next layer behind a start pulse and a ready handshake.
module pool_stride_obuf
    import pool_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int CHANNELS   = 256,
    parameter int IMG_DIM    = 13,
    parameter int KERNEL_DIM = 3,
    parameter int STRIDE     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           i_we,
    input  logic [CHANNELS*DATA_SIZE-1:0] i_data,
    input  logic                          i_start,
    output logic                          o_ready,
    input  logic                          i_next_ready,
    output logic [CHANNELS*DATA_SIZE-1:0] o_next_data,
    output logic [CHANNELS-1:0]           o_next_we,
    output logic                          o_next_start
);

    localparam int OUT_DIM = out_dim(IMG_DIM, KERNEL_DIM, STRIDE);
    localparam int DEPTH   = OUT_DIM * OUT_DIM;
    localparam int AW      = addr_w(DEPTH);
    localparam int CW      = addr_w(IMG_DIM);
    localparam int PW      = addr_w(STRIDE);
    localparam int W       = CHANNELS * DATA_SIZE;

    localparam logic [CW-1:0] IMG_LAST   = CW'(IMG_DIM - 1);
    localparam logic [CW-1:0] K_FIRST    = CW'(KERNEL_DIM - 1);
    localparam logic [PW-1:0] PH_LAST    = PW'(STRIDE - 1);
    localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);

    state_t state, state_nxt;

    logic [CW-1:0] row, col, cur_row, cur_col;
    logic [PW-1:0] row_ph, col_ph, cur_rph, cur_cph, rph_step, cph_step;
    logic [AW-1:0] wr_addr, rd_addr, rd_nxt;
    logic          we_d, keep_d, last_d;
    logic          start_ok, push, keep, is_last, ram_we;
    logic          unused_we;

    assign unused_we = ^i_we;

    assign o_ready  = (state == IDLE) || ((state == FILL) && !last_d);
    assign start_ok = i_start && o_ready;
    assign push     = i_we[0] && o_ready && ((state == FILL) || start_ok);

    // A start arriving with a strobe places that pixel at the origin
    assign cur_row  = start_ok ? '0 : row;
    assign cur_col  = start_ok ? '0 : col;
    assign cur_rph  = start_ok ? '0 : row_ph;
    assign cur_cph  = start_ok ? '0 : col_ph;
    assign rph_step = (cur_rph == PH_LAST) ? '0 : cur_rph + 1'b1;
    assign cph_step = (cur_cph == PH_LAST) ? '0 : cur_cph + 1'b1;

    assign keep    = (cur_row >= K_FIRST) && (cur_col >= K_FIRST) && (cur_rph == '0) && (cur_cph == '0);
    assign is_last = (cur_row == IMG_LAST) && (cur_col == IMG_LAST);

    // The capture pending on a restart belongs to the discarded image
    assign ram_we = we_d && keep_d && !start_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row     <= '0;
            col     <= '0;
            row_ph  <= '0;
            col_ph  <= '0;
            we_d    <= 1'b0;
            keep_d  <= 1'b0;
            last_d  <= 1'b0;
            wr_addr <= '0;
        end else begin
            we_d   <= push;
            keep_d <= push && keep;
            last_d <= push && is_last;
            if (push) begin
                if (cur_col == IMG_LAST) begin
                    col    <= '0;
                    col_ph <= '0;
                    if (cur_row == IMG_LAST) begin
                        row    <= '0;
                        row_ph <= '0;
                    end else begin
                        row    <= cur_row + 1'b1;
                        row_ph <= (cur_row >= K_FIRST) ? rph_step : cur_rph;
                    end
                end else begin
                    col    <= cur_col + 1'b1;
                    col_ph <= (cur_col >= K_FIRST) ? cph_step : cur_cph;
                    row    <= cur_row;
                    row_ph <= cur_rph;
                end
            end else if (start_ok) begin
                row    <= '0;
                col    <= '0;
                row_ph <= '0;
                col_ph <= '0;
            end
            if (start_ok) begin
                wr_addr <= '0;
            end else if (ram_we) begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rd_addr <= '0;
        end else begin
            state   <= state_nxt;
            rd_addr <= rd_nxt;
        end
    end

    // rd_nxt doubles as the RAM read address, so the entry on o_next_data is always rd_addr
    always_comb begin
        state_nxt    = state;
        rd_nxt       = rd_addr;
        o_next_we    = '0;
        o_next_start = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = FILL;
            end
            FILL: begin
                if (last_d) state_nxt = WAIT_NEXT;
            end
            WAIT_NEXT: begin
                if (i_next_ready) state_nxt = START;
            end
            START: begin
                o_next_start = 1'b1;
                rd_nxt       = '0;
                state_nxt    = DRAIN;
            end
            DRAIN: begin
                if (i_next_ready) begin
                    o_next_we = '1;
                    if (rd_addr == DEPTH_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        rd_nxt = rd_addr + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    obuf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .wr_addr (wr_addr),
        .wr_data (i_data),
        .rd_addr (rd_nxt),
        .rd_data (o_next_data)
    );

endmodule
